// File: rtl/axi_stream_mux_n.sv
// N-input AXI-stream multiplexer with a registered two-entry skid output stage.
// In packet mode the selection is frozen from the first beat of a packet until its tlast beat.
module axi_stream_mux_n #(
   parameter int DATA_WIDTH  = 16,
   parameter int DEST_WIDTH  = 8,
   parameter int USER_WIDTH  = 8,
   parameter int N_CHANNELS  = 8,
   parameter int PACKET_MODE = 1,
   parameter int SEL_WIDTH   = $clog2(N_CHANNELS)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [SEL_WIDTH-1:0]             address,
   input  logic [N_CHANNELS*DATA_WIDTH-1:0] stream_in_data,
   input  logic [N_CHANNELS*DEST_WIDTH-1:0] stream_in_dest,
   input  logic [N_CHANNELS*USER_WIDTH-1:0] stream_in_user,
   input  logic [N_CHANNELS-1:0]            stream_in_tlast,
   input  logic [N_CHANNELS-1:0]            stream_in_valid,
   output logic [N_CHANNELS-1:0]            stream_in_ready,
   output logic [DATA_WIDTH-1:0]            stream_out_data,
   output logic [DEST_WIDTH-1:0]            stream_out_dest,
   output logic [USER_WIDTH-1:0]            stream_out_user,
   output logic                             stream_out_tlast,
   output logic                             stream_out_valid,
   input  logic                             stream_out_ready,
   output logic [SEL_WIDTH-1:0]             active_channel,
   output logic                             channel_valid,
   output logic                             locked
);
   localparam int BEAT_WIDTH = DATA_WIDTH + DEST_WIDTH + USER_WIDTH + 1;
   localparam int N_SLOTS    = 1 << SEL_WIDTH;
   localparam logic [SEL_WIDTH:0] CHANNEL_LIMIT = (SEL_WIDTH+1)'(N_CHANNELS);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                state_reg, state_next;
   logic [SEL_WIDTH-1:0]  sel_reg;
   logic                  sel_valid_reg;
   logic [BEAT_WIDTH-1:0] out_beat_reg, skid_beat_reg;
   logic                  out_valid_reg, skid_full_reg;

   logic [BEAT_WIDTH-1:0] beat_arr [N_SLOTS];
   logic [N_SLOTS-1:0]    valid_arr;
   logic [BEAT_WIDTH-1:0] sel_beat;
   logic                  take_ready, accept, accept_last, hold_sel, address_in_range;

   // Pad the channel table to a power of two so any address indexes safely.
   generate
      for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
         if (gi < N_CHANNELS) begin : g_used
            assign beat_arr[gi]  = {stream_in_data[gi*DATA_WIDTH +: DATA_WIDTH],
                                    stream_in_dest[gi*DEST_WIDTH +: DEST_WIDTH],
                                    stream_in_user[gi*USER_WIDTH +: USER_WIDTH],
                                    stream_in_tlast[gi]};
            assign valid_arr[gi] = stream_in_valid[gi];
            assign stream_in_ready[gi] = take_ready & (sel_reg == SEL_WIDTH'(gi));
         end else begin : g_unused
            assign beat_arr[gi]  = '0;
            assign valid_arr[gi] = 1'b0;
         end
      end
   endgenerate

   assign take_ready       = sel_valid_reg & ~skid_full_reg;
   assign sel_beat         = beat_arr[sel_reg];
   assign accept           = take_ready & valid_arr[sel_reg];
   assign accept_last      = sel_beat[0];
   assign address_in_range = {1'b0, address} < CHANNEL_LIMIT;

   always_comb begin
      state_next = state_reg;
      if (PACKET_MODE != 0 && accept) begin
         if (state_reg == IDLE && !accept_last)
            state_next = LOCKED;
         else if (state_reg == LOCKED && accept_last)
            state_next = IDLE;
      end
   end

   // Freeze the selection on the edge that takes a packet's first beat as well.
   assign hold_sel = (state_reg == LOCKED) || (state_next == LOCKED);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         sel_reg       <= '0;
         sel_valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (!hold_sel) begin
            sel_reg       <= address;
            sel_valid_reg <= address_in_range;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_reg <= 1'b0;
         out_beat_reg  <= '0;
         skid_full_reg <= 1'b0;
         skid_beat_reg <= '0;
      end else if (!out_valid_reg || stream_out_ready) begin
         // Input ready is low while the skid holds a beat, so no accept competes here.
         if (skid_full_reg) begin
            out_beat_reg  <= skid_beat_reg;
            out_valid_reg <= 1'b1;
            skid_full_reg <= 1'b0;
         end else begin
            out_valid_reg <= accept;
            if (accept)
               out_beat_reg <= sel_beat;
         end
      end else if (accept) begin
         skid_beat_reg <= sel_beat;
         skid_full_reg <= 1'b1;
      end
   end

   assign {stream_out_data, stream_out_dest, stream_out_user, stream_out_tlast} = out_beat_reg;
   assign stream_out_valid = out_valid_reg;
   assign active_channel   = sel_reg;
   assign channel_valid    = sel_valid_reg;
   assign locked           = (state_reg == LOCKED);
endmodule

// File: tb/tb_axi_stream_mux_n.sv
// Directed bench for axi_stream_mux_n: two 8-channel instances (packet mode on/off)
// and one 6-channel instance for out-of-range addressing.
module tb_axi_stream_mux_n;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // index 0: PACKET_MODE=1, index 1: PACKET_MODE=0
   logic [2:0]   address   [2];
   logic [127:0] in_data   [2];
   logic [63:0]  in_dest   [2];
   logic [63:0]  in_user   [2];
   logic [7:0]   in_last   [2];
   logic [7:0]   in_valid  [2];
   logic [7:0]   in_ready  [2];
   logic [15:0]  out_data  [2];
   logic [7:0]   out_dest  [2];
   logic [7:0]   out_user  [2];
   logic         out_last  [2];
   logic         out_valid [2];
   logic         out_ready [2];
   logic [2:0]   active    [2];
   logic         chv       [2];
   logic         lk        [2];

   logic [2:0]  c_address;
   logic [95:0] c_in_data;
   logic [47:0] c_in_dest, c_in_user;
   logic [5:0]  c_in_last, c_in_valid, c_in_ready;
   logic [15:0] c_out_data;
   logic [7:0]  c_out_dest, c_out_user;
   logic        c_out_last, c_out_valid, c_out_ready;
   logic [2:0]  c_active;
   logic        c_chv, c_lk;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         axi_stream_mux_n #(
            .DATA_WIDTH(16), .DEST_WIDTH(8), .USER_WIDTH(8),
            .N_CHANNELS(8), .PACKET_MODE(gi == 0 ? 1 : 0)
         ) u_dut (
            .clock(clock), .reset(reset), .address(address[gi]),
            .stream_in_data(in_data[gi]), .stream_in_dest(in_dest[gi]),
            .stream_in_user(in_user[gi]), .stream_in_tlast(in_last[gi]),
            .stream_in_valid(in_valid[gi]), .stream_in_ready(in_ready[gi]),
            .stream_out_data(out_data[gi]), .stream_out_dest(out_dest[gi]),
            .stream_out_user(out_user[gi]), .stream_out_tlast(out_last[gi]),
            .stream_out_valid(out_valid[gi]), .stream_out_ready(out_ready[gi]),
            .active_channel(active[gi]), .channel_valid(chv[gi]), .locked(lk[gi])
         );
      end
   endgenerate

   axi_stream_mux_n #(
      .DATA_WIDTH(16), .DEST_WIDTH(8), .USER_WIDTH(8), .N_CHANNELS(6), .PACKET_MODE(1)
   ) u_dut_n6 (
      .clock(clock), .reset(reset), .address(c_address),
      .stream_in_data(c_in_data), .stream_in_dest(c_in_dest),
      .stream_in_user(c_in_user), .stream_in_tlast(c_in_last),
      .stream_in_valid(c_in_valid), .stream_in_ready(c_in_ready),
      .stream_out_data(c_out_data), .stream_out_dest(c_out_dest),
      .stream_out_user(c_out_user), .stream_out_tlast(c_out_last),
      .stream_out_valid(c_out_valid), .stream_out_ready(c_out_ready),
      .active_channel(c_active), .channel_valid(c_chv), .locked(c_lk)
   );

   task automatic clear_inputs();
      for (int d = 0; d < 2; d++) begin
         address[d] = 3'd0; in_data[d] = '0; in_dest[d] = '0; in_user[d] = '0;
         in_last[d] = '0; in_valid[d] = '0; out_ready[d] = 1'b0;
      end
      c_address = 3'd0; c_in_data = '0; c_in_dest = '0; c_in_user = '0;
      c_in_last = '0; c_in_valid = '0; c_out_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      clear_inputs();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      @(negedge clock);
      #1;
      for (int d = 0; d < 2; d++) begin
         total++;
         if (out_valid[d] !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", d, out_valid[d]);
         end
         total++;
         if ({out_data[d], out_dest[d], out_user[d], out_last[d]} !== 33'h0) begin
            bad++; $display("FAIL reset_out_beat[%0d]: got %h expected 0", d,
                            {out_data[d], out_dest[d], out_user[d], out_last[d]});
         end
         total++;
         if (in_ready[d] !== 8'h00) begin
            bad++; $display("FAIL reset_ready[%0d]: got %h expected 00", d, in_ready[d]);
         end
         total++;
         if ({active[d], chv[d], lk[d]} !== 5'b0) begin
            bad++; $display("FAIL reset_status[%0d]: got %b expected 00000", d, {active[d], chv[d], lk[d]});
         end
      end
      total++;
      if ({c_out_valid, c_in_ready, c_chv, c_lk} !== 9'b0) begin
         bad++; $display("FAIL reset_n6: got %b expected 000000000", {c_out_valid, c_in_ready, c_chv, c_lk});
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   // 16 beats from channel 2; toggle=1 alternates stream_out.ready every cycle
   task automatic test_stream(input bit toggle);
      int k_in, k_out, occ, first_acc, first_out, last_out;
      bit acc, hs, stall_prev;
      logic [32:0] beat, exp_beat, prev_beat;
      k_in = 0; k_out = 0; occ = 0; first_acc = -1; first_out = -1; last_out = -1;
      stall_prev = 1'b0; prev_beat = '0;
      @(negedge clock);
      address[0] = 3'd2;
      out_ready[0] = 1'b1;
      for (int cyc = 0; cyc < 80 && k_out < 16; cyc++) begin
         @(negedge clock);
         if (toggle) out_ready[0] = (cyc % 2 == 0);
         in_valid[0][2] = (k_in < 16);
         in_data[0][2*16 +: 16] = 16'h0100 + 16'(k_in);
         in_dest[0][2*8 +: 8]   = 8'h20 + 8'(k_in);
         in_user[0][2*8 +: 8]   = 8'h80 + 8'(k_in);
         in_last[0][2]          = (k_in == 15);
         #1;
         beat = {out_data[0], out_dest[0], out_user[0], out_last[0]};
         total++;
         if ((in_ready[0] & 8'hFB) !== 8'h00) begin
            bad++; $display("FAIL other_ready: got %h expected 00", in_ready[0]);
         end
         total++;
         if (in_ready[0][2] !== (occ < 2)) begin
            bad++; $display("FAIL ready2 cyc=%0d occ=%0d: got %b expected %b", cyc, occ, in_ready[0][2], occ < 2);
         end
         if (stall_prev) begin
            total++;
            if (out_valid[0] !== 1'b1 || beat !== prev_beat) begin
               bad++; $display("FAIL stall_hold cyc=%0d: got v=%b %h expected v=1 %h", cyc, out_valid[0], beat, prev_beat);
            end
         end
         acc = in_valid[0][2] & in_ready[0][2];
         hs  = out_valid[0] & out_ready[0];
         if (hs) begin
            exp_beat = {16'h0100 + 16'(k_out), 8'h20 + 8'(k_out), 8'h80 + 8'(k_out), k_out == 15};
            total++;
            if (beat !== exp_beat) begin
               bad++; $display("FAIL stream_beat %0d: got %h expected %h", k_out, beat, exp_beat);
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            k_out++;
         end
         if (acc && first_acc < 0) first_acc = cyc;
         stall_prev = out_valid[0] & ~out_ready[0];
         prev_beat  = beat;
         occ = occ + int'(acc) - int'(hs);
         if (acc) k_in++;
      end
      in_valid[0] = '0;
      total++;
      if (k_out != 16) begin
         bad++; $display("FAIL stream_count toggle=%0d: got %0d expected 16", toggle, k_out);
      end
      if (!toggle) begin
         total++;
         if (first_out != first_acc + 1) begin
            bad++; $display("FAIL stream_latency: got out@%0d expected %0d", first_out, first_acc + 1);
         end
         total++;
         if (last_out - first_out != 15) begin
            bad++; $display("FAIL stream_throughput: got span %0d expected 15", last_out - first_out);
         end
      end
   endtask

   // Channel 1 sends a 4-beat packet, channel 5 a 2-beat packet; address 1->5 after beat 2
   task automatic test_packet_switch();
      int p1 [2]; int p5 [2]; int n_got [2]; int sw_cyc [2]; int exp_n [2];
      bit in_pkt [2];
      bit a1, a5;
      logic [15:0] got [2][8];
      logic [15:0] exp_seq [2][6];
      exp_seq[0][0] = 16'h0010; exp_seq[0][1] = 16'h0011; exp_seq[0][2] = 16'h0012;
      exp_seq[0][3] = 16'h0013; exp_seq[0][4] = 16'h0050; exp_seq[0][5] = 16'h0051;
      exp_seq[1][0] = 16'h0010; exp_seq[1][1] = 16'h0011; exp_seq[1][2] = 16'h0012;
      exp_seq[1][3] = 16'h0050; exp_seq[1][4] = 16'h0051; exp_seq[1][5] = 16'h0000;
      exp_n[0] = 6; exp_n[1] = 5;
      do_reset();
      for (int d = 0; d < 2; d++) begin
         p1[d] = 0; p5[d] = 0; n_got[d] = 0; sw_cyc[d] = -1; in_pkt[d] = 1'b0;
         address[d] = 3'd1; out_ready[d] = 1'b1;
      end
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clock);
         for (int d = 0; d < 2; d++) begin
            if (sw_cyc[d] < 0 && p1[d] == 2) begin
               address[d] = 3'd5; sw_cyc[d] = cyc;
            end
            in_valid[d][1] = (p1[d] < 4);
            in_data[d][16 +: 16] = 16'h0010 + 16'(p1[d]);
            in_last[d][1] = (p1[d] == 3);
            in_valid[d][5] = (p5[d] < 2);
            in_data[d][80 +: 16] = 16'h0050 + 16'(p5[d]);
            in_last[d][5] = (p5[d] == 1);
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            total++;
            if (lk[d] !== (d == 0 ? in_pkt[d] : 1'b0)) begin
               bad++; $display("FAIL locked[%0d] cyc=%0d: got %b expected %b", d, cyc, lk[d], (d == 0 ? in_pkt[d] : 1'b0));
            end
            if (sw_cyc[d] >= 0 && cyc == sw_cyc[d] + 1) begin
               total++;
               if (active[d] !== (d == 0 ? 3'd1 : 3'd5)) begin
                  bad++; $display("FAIL switch_active[%0d]: got %0d expected %0d", d, active[d], (d == 0 ? 1 : 5));
               end
            end
            if (out_valid[d]) begin
               if (n_got[d] < 8) got[d][n_got[d]] = out_data[d];
               n_got[d]++;
            end
            a1 = in_valid[d][1] & in_ready[d][1];
            a5 = in_valid[d][5] & in_ready[d][5];
            if (a1) begin p1[d]++; in_pkt[d] = !in_last[d][1]; end
            if (a5) begin p5[d]++; in_pkt[d] = !in_last[d][5]; end
         end
      end
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = '0;
         total++;
         if (n_got[d] != exp_n[d]) begin
            bad++; $display("FAIL switch_count[%0d]: got %0d expected %0d", d, n_got[d], exp_n[d]);
         end
         for (int i = 0; i < exp_n[d] && i < n_got[d]; i++) begin
            total++;
            if (got[d][i] !== exp_seq[d][i]) begin
               bad++; $display("FAIL switch_order[%0d] beat %0d: got %h expected %h", d, i, got[d][i], exp_seq[d][i]);
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      int k, n;
      do_reset();
      c_address = 3'd3;
      c_out_ready = 1'b0;
      k = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clock);
         c_in_valid[3] = 1'b1;
         c_in_data[3*16 +: 16] = 16'h0300 + 16'(k);
         c_in_last[3] = 1'b1;
         #1;
         if (c_in_valid[3] & c_in_ready[3]) k++;
      end
      total++;
      if (k != 2) begin
         bad++; $display("FAIL oor_fill: got %0d accepts expected 2", k);
      end
      @(negedge clock);
      c_address = 3'd7;
      @(negedge clock);
      #1;
      total++;
      if ({c_chv, c_active} !== 4'b0_111) begin
         bad++; $display("FAIL oor_status: got chv=%b active=%0d expected chv=0 active=7", c_chv, c_active);
      end
      c_out_ready = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         total++;
         if (c_in_ready !== 6'h00) begin
            bad++; $display("FAIL oor_ready: got %h expected 00", c_in_ready);
         end
         if (c_out_valid) begin
            total++;
            if (c_out_data !== 16'h0300 + 16'(n)) begin
               bad++; $display("FAIL oor_drain %0d: got %h expected %h", n, c_out_data, 16'h0300 + 16'(n));
            end
            n++;
         end
         @(negedge clock);
         #1;
      end
      total++;
      if (n != 2 || c_out_valid !== 1'b0) begin
         bad++; $display("FAIL oor_drained: got %0d beats valid=%b expected 2 beats valid=0", n, c_out_valid);
      end
      c_in_valid = '0;
   endtask

   task automatic test_async_reset();
      int k, n;
      bit checked;
      @(negedge clock);
      address[0] = 3'd0;
      out_ready[0] = 1'b0;
      k = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clock);
         in_valid[0][0] = 1'b1;
         in_data[0][15:0] = 16'h0600 + 16'(k);
         in_last[0][0] = 1'b0;
         #1;
         if (in_valid[0][0] & in_ready[0][0]) k++;
      end
      total++;
      if (k != 2 || in_ready[0] !== 8'h00 || out_valid[0] !== 1'b1 || lk[0] !== 1'b1) begin
         bad++; $display("FAIL arst_prefill: got k=%0d ready=%h valid=%b locked=%b expected k=2 ready=00 valid=1 locked=1",
                         k, in_ready[0], out_valid[0], lk[0]);
      end
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 8'h00) begin
         bad++; $display("FAIL arst_immediate: got valid=%b ready=%h expected valid=0 ready=00", out_valid[0], in_ready[0]);
      end
      total++;
      if ({lk[0], chv[0]} !== 2'b00) begin
         bad++; $display("FAIL arst_status: got locked=%b chv=%b expected 0 0", lk[0], chv[0]);
      end
      out_ready[0] = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      k = 0; n = 0; checked = 1'b0;
      for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
         in_valid[0][0] = (k < 3);
         in_data[0][15:0] = 16'h0700 + 16'(k);
         in_last[0][0] = (k == 2);
         #1;
         if (out_valid[0]) begin
            total++;
            if (out_data[0] !== 16'h0700 + 16'(n)) begin
               bad++; $display("FAIL arst_packet %0d: got %h expected %h", n, out_data[0], 16'h0700 + 16'(n));
            end
            n++;
         end
         if (k == 1 && !checked) begin
            checked = 1'b1;
            total++;
            if (lk[0] !== 1'b1) begin
               bad++; $display("FAIL arst_relock: got %b expected 1", lk[0]);
            end
         end
         if (in_valid[0][0] & in_ready[0][0]) k++;
         @(negedge clock);
      end
      #1;
      total++;
      if (n != 3 || lk[0] !== 1'b0) begin
         bad++; $display("FAIL arst_done: got %0d beats locked=%b expected 3 beats locked=0", n, lk[0]);
      end
      in_valid[0] = '0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_stream(1'b0);
      test_stream(1'b1);
      test_packet_switch();
      test_out_of_range();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/axi_stream_mux_n.md
Name: axi_stream_mux_n

Overview:
- Parametrised N-input AXI-stream multiplexer; successor to the fixed 8-way mux.
- Routes one of N_CHANNELS slave streams to a single master stream.
- The output is registered through a skid buffer, so the mux sustains full throughput with correct backpressure.
- Optional packet-aware mode: the selection can only change on packet boundaries (tlast), so packets are never interleaved.
- Sits between multiple producers (ADC/scope/control streams) and a shared consumer (DMA, scope buffer).

Parameters:
- DATA_WIDTH, 16, width of data on all streams.
- DEST_WIDTH, 8, width of dest on all streams.
- USER_WIDTH, 8, width of user on all streams.
- N_CHANNELS, 8, number of input streams; 2..32.
- PACKET_MODE, 1, 0 = selection follows address whenever unlocked each cycle; 1 = selection locked from first beat of a packet until its tlast beat.
- SEL_WIDTH, $clog2(N_CHANNELS), width of address.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- address, input, SEL_WIDTH, requested input channel; values >= N_CHANNELS select nothing.
- stream_in, axi_stream.slave, array [N_CHANNELS], input streams (data, dest, user, tlast, valid, ready).
- stream_out, axi_stream.master, 1, muxed output stream.
- active_channel, output, SEL_WIDTH, currently registered selection.
- channel_valid, output, 1, high when active_channel < N_CHANNELS.
- locked, output, 1, high while a packet is in flight (PACKET_MODE=1 only; tied 0 otherwise).

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset); all state is cleared immediately on assertion.
- Reset values:
  - stream_out.valid=0; data, dest, user and tlast=0.
  - All stream_in[i].ready=0.
  - active_channel=0; channel_valid=0; locked=0.
  - Skid buffer empty; FSM in IDLE.
- Selection register sel_r:
  - When unlocked, sel_r <= address at each clock edge, so a selection change takes effect one cycle after address changes.
  - When locked, sel_r holds.
- Input ready:
  - stream_in[sel_r].ready = channel_valid & ~skid_full.
  - Every other ready = 0.
  - All readies are 0 if sel_r is out of range.
- Accept = valid & ready on the selected input.
- Output stage (2-entry skid):
  - Out register empty, or stream_out.ready high: the accepted beat loads the out register. Latency is 1 cycle from accept to stream_out.valid.
  - Out register full and stream_out.ready low: the accepted beat goes to the skid register; skid_full then drops the input ready.
  - When the out register is consumed and skid_full is set, the skid beat moves to the out register and skid_full clears.
  - stream_out.valid never drops without a handshake; data, dest, user and tlast are stable while valid & ~ready.
  - 100% throughput when stream_out.ready is held high.
- FSM (PACKET_MODE=1):
  - IDLE: unlocked. Accept with tlast=0 -> LOCKED. Accept with tlast=1 (single-beat packet) -> stay IDLE.
  - LOCKED: sel_r frozen; locked=1. Accept with tlast=1 -> IDLE, and sel_r may reload from address on the following edge.
  - An address change while LOCKED is ignored until the packet ends, then applied.
- PACKET_MODE=0: FSM is always IDLE; beats from different channels may interleave at beat granularity.
- Switching never drops or duplicates a beat: beats already in the out/skid registers drain in order regardless of the selection change.
- Out-of-range address: no input accepted; buffered beats still drain.
- Reset mid-packet: buffered beats are discarded, FSM returns to IDLE, and the first post-reset beat is treated as packet start.

Test Plan:
- Reset then address=2, stream_in[2] sends 16 beats data=0x100+k, stream_out.ready=1 -> output matches in order, one beat per cycle, first output 1 cycle after first accept; all other readies 0.
- Same stream, stream_out.ready toggled 1/0 every cycle -> no loss or duplication; stream_in[2].ready drops only when skid is full; output stable while stalled.
- PACKET_MODE=1: channel 1 sends a 4-beat packet; address switches 1->5 after beat 2 -> beats 3-4 still from channel 1, locked=1 until tlast; channel 5 data appears only after the channel 1 tlast beat.
- PACKET_MODE=0, same stimulus -> selection switches the cycle after the address change; locked stays 0.
- N_CHANNELS=6, address=7 -> channel_valid=0, all readies 0, stream_out.valid falls once buffered beats drain.
- Assert reset asynchronously mid-packet with the skid full -> stream_out.valid=0 and readies=0 immediately (before the next clock edge); after release, a new packet on address 0 passes cleanly.
